// File: rtl/ofdm_pkg.sv
// Shared OFDM framing constants, bin classification and beat format for the TX inserter and RX remover.
package ofdm_pkg;
  localparam int FFT_POINT      = 64;
  localparam int ACTIVE_SUBCARR = 28;
  localparam int CEST_NUM       = 4;
  localparam int SYMBOL_NUM     = 8;
  localparam int SYM_TOTAL      = CEST_NUM + SYMBOL_NUM;
  localparam int DW             = 16;
  localparam int RAM_DEPTH      = ACTIVE_SUBCARR * SYM_TOTAL;

  localparam logic [5:0] LAST_DIRECT  = 6'(ACTIVE_SUBCARR);
  localparam logic [5:0] FIRST_MIRROR = 6'(FFT_POINT - ACTIVE_SUBCARR);
  localparam logic [5:0] LAST_BIN     = 6'(FFT_POINT - 1);
  localparam logic [3:0] LAST_SYM     = 4'(SYM_TOTAL - 1);

  typedef enum logic [1:0] {BIN_ZERO, BIN_DIRECT, BIN_MIRROR} bin_class_e;

  typedef struct packed {
    logic [DW-1:0] dat;
    logic          last;
    logic [3:0]    sym;
  } beat_t;

  function automatic bin_class_e bin_class(input logic [5:0] n);
    bin_class_e c;
    if (n == 6'd0)               c = BIN_ZERO;
    else if (n <= LAST_DIRECT)   c = BIN_DIRECT;
    else if (n >= FIRST_MIRROR)  c = BIN_MIRROR;
    else                         c = BIN_ZERO;
    return c;
  endfunction

  // Negating -128 would wrap back to -128, so it clamps to +127.
  function automatic logic [DW-1:0] conj_sat(input logic [DW-1:0] s);
    logic [7:0] q;
    q = s[7:0];
    return {s[15:8], (q == 8'h80) ? 8'h7F : (8'h00 - q)};
  endfunction
endpackage

// File: rtl/herm_ins_ram.sv
// Simple dual-port burst buffer: one write port, one read port with a single registered read cycle.
module herm_ins_ram
  import ofdm_pkg::*;
(
  input  logic          clk,
  input  logic          we_i,
  input  logic [8:0]    wr_addr_i,
  input  logic [DW-1:0] wr_dat_i,
  input  logic          re_i,
  input  logic [8:0]    rd_addr_i,
  output logic [DW-1:0] rd_dat_o
);
  logic [DW-1:0] mem_q [RAM_DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[wr_addr_i] <= wr_dat_i;
    if (re_i) rd_dat_o <= mem_q[rd_addr_i];
  end
endmodule

// File: rtl/hermitian_inserter.sv
// Buffers one 12x28 burst, then emits 12 Hermitian-symmetric 64-bin frames; 2 cycles from EMIT entry to
// first beat, 1 beat/cycle when unstalled; a 2-entry FIFO absorbs dout_ready backpressure without loss.
module hermitian_inserter
  import ofdm_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic [DW-1:0] din,
  input  logic          din_valid,
  output logic          din_ready,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          dout_last,
  output logic [3:0]    dout_sym,
  output logic          frame_done
);
  typedef enum logic {ST_LOAD, ST_EMIT} state_e;

  state_e        state_q;
  logic [8:0]    wr_addr_q;
  logic [3:0]    sym_q;
  logic [5:0]    n_q;
  logic          gen_done_q;
  logic          in_flight_q;
  bin_class_e    stg_cls_q;
  logic          stg_last_q;
  logic [3:0]    stg_sym_q;
  beat_t         fifo_q [2];
  logic          wr_ptr_q, rd_ptr_q;
  logic [1:0]    count_q, count_d;

  logic          accept, pop, push, issue, final_beat, re;
  bin_class_e    cls;
  logic [5:0]    idx;
  logic [8:0]    rd_addr;
  logic [DW-1:0] rd_dat;
  beat_t         head, stg_beat;

  assign din_ready  = (state_q == ST_LOAD);
  assign accept     = din_valid & din_ready;
  assign head       = fifo_q[rd_ptr_q];
  assign dout_valid = (count_q != 2'd0);
  assign dout       = head.dat;
  assign dout_last  = head.last;
  assign dout_sym   = head.sym;
  assign pop        = dout_valid & dout_ready;
  assign push       = in_flight_q;
  assign final_beat = pop & head.last & (head.sym == LAST_SYM);
  assign frame_done = final_beat & ~flush;

  // Occupancy is taken after this cycle's pop so a steady stream keeps one beat in the FIFO and one in flight.
  assign issue = (state_q == ST_EMIT) & ~gen_done_q & ~flush &
                 ((count_q - 2'(pop) + 2'(in_flight_q)) < 2'd2);

  assign cls     = bin_class(n_q);
  assign idx     = (cls == BIN_MIRROR) ? (LAST_BIN - n_q) : (n_q - 6'd1);
  assign rd_addr = {1'b0, sym_q, 4'b0} + {2'b0, sym_q, 3'b0} + {3'b0, sym_q, 2'b0} + {3'b0, idx};
  assign re      = issue & (cls != BIN_ZERO);

  herm_ins_ram u_ram (
    .clk       (clk),
    .we_i      (accept & ~flush),
    .wr_addr_i (wr_addr_q),
    .wr_dat_i  (din),
    .re_i      (re),
    .rd_addr_i (rd_addr),
    .rd_dat_o  (rd_dat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_LOAD;
      wr_addr_q  <= '0;
      sym_q      <= '0;
      n_q        <= '0;
      gen_done_q <= 1'b0;
    end else if (flush) begin
      state_q    <= ST_LOAD;
      wr_addr_q  <= '0;
      sym_q      <= '0;
      n_q        <= '0;
      gen_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (accept) begin
            if (wr_addr_q == 9'(RAM_DEPTH - 1)) begin
              wr_addr_q <= '0;
              state_q   <= ST_EMIT;
            end else begin
              wr_addr_q <= wr_addr_q + 9'd1;
            end
          end
        end
        default: begin
          if (issue) begin
            if (n_q == LAST_BIN) begin
              n_q <= '0;
              if (sym_q == LAST_SYM) gen_done_q <= 1'b1;
              else                   sym_q      <= sym_q + 4'd1;
            end else begin
              n_q <= n_q + 6'd1;
            end
          end
          if (final_beat) begin
            state_q    <= ST_LOAD;
            sym_q      <= '0;
            n_q        <= '0;
            gen_done_q <= 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_flight_q <= 1'b0;
      stg_cls_q   <= BIN_ZERO;
      stg_last_q  <= 1'b0;
      stg_sym_q   <= '0;
    end else begin
      in_flight_q <= issue;
      stg_cls_q   <= cls;
      stg_last_q  <= (n_q == LAST_BIN);
      stg_sym_q   <= sym_q;
    end
  end

  always_comb begin
    stg_beat      = '0;
    stg_beat.last = stg_last_q;
    stg_beat.sym  = stg_sym_q;
    case (stg_cls_q)
      BIN_DIRECT: stg_beat.dat = rd_dat;
      BIN_MIRROR: stg_beat.dat = conj_sat(rd_dat);
      default:    stg_beat.dat = '0;
    endcase
  end

  always_comb begin
    count_d = count_q + 2'(push) - 2'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= '0;
    end else if (flush) begin
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= stg_beat;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end
endmodule
